// File: rtl/cusp_seq_pkg.sv
// Shared types and constants for the cusp peak sequencer.
//   DATA_W      : full signed sample width (SIZE_FILTER_DATA+1)
//   LOST_W      : width of the saturating lost-crossing counter
//   *_DEF       : parameter defaults for the sequencer
//   seq_state_t : sequencer FSM states
package cusp_seq_pkg;
  import package_settings::*;

  localparam int DATA_W        = SIZE_FILTER_DATA + 1;
  localparam int LOST_W        = 16;
  localparam int SHAPE_LEN_DEF = 32;
  localparam int DEAD_TIME_DEF = 16;
  localparam int TS_W_DEF      = 32;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARMED  = 3'd1,
    ST_SEARCH = 3'd2,
    ST_OUTPUT = 3'd3,
    ST_DEAD   = 3'd4
  } seq_state_t;
endpackage

// File: rtl/package_settings.sv
// Project-wide settings shared by the acquisition chain.
// SIZE_FILTER_DATA is the MSB index of the filter output, so samples are
// SIZE_FILTER_DATA+1 bits wide and signed.
package package_settings;
  localparam int SIZE_FILTER_DATA = 15;
endpackage

// File: rtl/thr_cross_det.sv
// Threshold crossing detector.
// Compares each filter sample against the trigger level (signed, strict),
// keeps a registered copy of the comparison and flags the rising crossing.
//   clk, reset   : clock, asynchronous active-low reset
//   filter_data  : signed filter sample
//   threshold    : signed trigger level
//   above        : filter_data > threshold for the current sample
//   crossing     : above now, not above on the previous sample
module thr_cross_det
  import cusp_seq_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [DATA_W-1:0] filter_data,
  input  logic signed [DATA_W-1:0] threshold,
  output logic                     above,
  output logic                     crossing
);

  logic above_q;

  // Both operands are declared signed, so this is a signed compare.
  assign above    = (filter_data > threshold);
  assign crossing = above & ~above_q;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) above_q <= 1'b0;
    else        above_q <= above;
  end

endmodule

// File: rtl/cusp_peak_sequencer.sv
// Acquisition sequencer behind the cusp-like shaping filter.
// Arms on a fresh threshold crossing, tracks the pulse to its peak (or to a
// SHAPE_LEN timeout, flagged as pile-up), offers one event over valid/ready,
// then holds off for DEAD_TIME cycles and until the signal drops below the
// threshold before re-arming. Crossings seen while an event is pending or
// during dead time are counted in a saturating counter.
//   clk, reset  : clock, asynchronous active-low reset
//   filter_data : signed filter sample, one per clock
//   threshold   : signed trigger level
//   enable      : acquisition enable
//   ev_valid    : event available         ev_ready : readout accepts event
//   ev_amp      : signed peak amplitude   ev_time  : timestamp of the peak
//   ev_pileup   : peak not found within SHAPE_LEN
//   busy        : state is SEARCH, OUTPUT or DEAD
//   lost_count  : crossings missed while an event was pending or in dead time
module cusp_peak_sequencer
  import cusp_seq_pkg::*;
#(
  parameter int SHAPE_LEN = SHAPE_LEN_DEF,
  parameter int DEAD_TIME = DEAD_TIME_DEF,
  parameter int TS_W      = TS_W_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [DATA_W-1:0] filter_data,
  input  logic signed [DATA_W-1:0] threshold,
  input  logic                     enable,
  output logic                     ev_valid,
  input  logic                     ev_ready,
  output logic signed [DATA_W-1:0] ev_amp,
  output logic        [TS_W-1:0]   ev_time,
  output logic                     ev_pileup,
  output logic                     busy,
  output logic        [LOST_W-1:0] lost_count
);

  localparam int CNT_W  = $clog2(SHAPE_LEN);
  localparam int DEAD_W = (DEAD_TIME > 1) ? $clog2(DEAD_TIME) : 1;

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(SHAPE_LEN - 1);
  localparam logic [DEAD_W-1:0] DEAD_LOAD = DEAD_W'(DEAD_TIME - 1);

  seq_state_t state_q, state_d;

  logic        [TS_W-1:0]   ts_q;
  logic signed [DATA_W-1:0] amp_q;
  logic        [TS_W-1:0]   t_pk_q;
  logic        [CNT_W-1:0]  cnt_q;
  logic        [DEAD_W-1:0] dead_q;

  logic above, crossing;

  // FSM strobes
  logic arm_load;
  logic latch_ev;
  logic latch_pileup;
  logic load_dead;
  logic xfer;

  // Peak tracking helpers
  logic                     greater;
  logic                     falling;
  logic                     timeout;
  logic signed [DATA_W-1:0] amp_new;
  logic        [TS_W-1:0]   t_new;

  thr_cross_det u_cross (
    .clk         (clk),
    .reset       (reset),
    .filter_data (filter_data),
    .threshold   (threshold),
    .above       (above),
    .crossing    (crossing)
  );

  // Ties keep the earlier sample: only a strictly larger value moves the peak.
  assign greater = (filter_data > amp_q);
  assign falling = (filter_data < amp_q);
  assign timeout = (cnt_q == CNT_LAST);
  // On a fall greater is 0, so amp_new/t_new equal the tracked peak; on a
  // timeout they also absorb the final search sample.
  assign amp_new = greater ? filter_data : amp_q;
  assign t_new   = greater ? ts_q        : t_pk_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every signal driven here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    arm_load     = 1'b0;
    latch_ev     = 1'b0;
    latch_pileup = 1'b0;
    load_dead    = 1'b0;
    xfer         = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (enable) state_d = ST_ARMED;
      end

      ST_ARMED: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (crossing) begin
          arm_load = 1'b1;
          state_d  = ST_SEARCH;
        end
      end

      ST_SEARCH: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (falling) begin
          // A fall takes precedence over a coincident timeout.
          latch_ev = 1'b1;
          state_d  = ST_OUTPUT;
        end else if (timeout) begin
          latch_ev     = 1'b1;
          latch_pileup = 1'b1;
          state_d      = ST_OUTPUT;
        end
      end

      ST_OUTPUT: begin
        // ev_valid is high for the whole OUTPUT state, so ready alone
        // marks the transfer edge. A disabled sequencer still delivers.
        if (ev_ready) begin
          xfer = 1'b1;
          if (enable) begin
            load_dead = 1'b1;
            state_d   = ST_DEAD;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      ST_DEAD: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (dead_q == '0 && !above) begin
          state_d = ST_ARMED;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Free-running timestamp; wraps naturally at TS_W bits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ts_q <= '0;
    else        ts_q <= ts_q + 1'b1;
  end

  // Peak tracker: seeded by the crossing sample, updated on strict rises.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      amp_q  <= '0;
      t_pk_q <= '0;
      cnt_q  <= '0;
    end else if (arm_load) begin
      amp_q  <= filter_data;
      t_pk_q <= ts_q;
      cnt_q  <= '0;
    end else if (state_q == ST_SEARCH) begin
      cnt_q <= cnt_q + 1'b1;
      if (greater) begin
        amp_q  <= filter_data;
        t_pk_q <= ts_q;
      end
    end
  end

  // Event registers: loaded once on peak/timeout, then held until transfer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ev_valid  <= 1'b0;
      ev_amp    <= '0;
      ev_time   <= '0;
      ev_pileup <= 1'b0;
    end else if (latch_ev) begin
      ev_valid  <= 1'b1;
      ev_amp    <= amp_new;
      ev_time   <= t_new;
      ev_pileup <= latch_pileup;
    end else if (xfer) begin
      ev_valid <= 1'b0;
    end
  end

  // Dead counter holds DEAD_TIME-1 on entry, so DEAD lasts DEAD_TIME
  // cycles minimum before the re-arm condition is even looked at.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dead_q <= '0;
    end else if (load_dead) begin
      dead_q <= DEAD_LOAD;
    end else if (state_q == ST_DEAD && dead_q != '0) begin
      dead_q <= dead_q - 1'b1;
    end
  end

  // busy is registered from the next state so it lines up with state_q.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) busy <= 1'b0;
    else        busy <= (state_d != ST_IDLE) && (state_d != ST_ARMED);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lost_count <= '0;
    end else if (crossing && (state_q == ST_OUTPUT || state_q == ST_DEAD)
                 && lost_count != '1) begin
      lost_count <= lost_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_cusp_peak_sequencer.sv
// Self-checking bench for cusp_peak_sequencer. Inputs change 1 ns after the
// rising edge, outputs are sampled on the falling edge. Expected events are
// queued when the peak sample is driven and compared while ev_valid is high.
module tb_cusp_peak_sequencer;
  import cusp_seq_pkg::*;

  localparam int SHAPE_LEN = 32;
  localparam int DEAD_TIME = 16;
  localparam int TS_W      = 32;

  logic                     clk;
  logic                     rst_n;
  logic signed [DATA_W-1:0] filter_data;
  logic signed [DATA_W-1:0] threshold;
  logic                     enable;
  logic                     ev_valid;
  logic                     ev_ready;
  logic signed [DATA_W-1:0] ev_amp;
  logic        [TS_W-1:0]   ev_time;
  logic                     ev_pileup;
  logic                     busy;
  logic        [LOST_W-1:0] lost_count;

  typedef struct {
    logic signed [DATA_W-1:0] amp;
    logic        [TS_W-1:0]   t;
    logic                     pu;
  } ev_t;

  ev_t         sb[$];
  int          seq[$];
  int          checks   = 0;
  int          failures = 0;
  int          n_ev     = 0;
  int unsigned ts_m;

  cusp_peak_sequencer #(
    .SHAPE_LEN (SHAPE_LEN),
    .DEAD_TIME (DEAD_TIME),
    .TS_W      (TS_W)
  ) dut (
    .clk         (clk),
    .reset       (rst_n),
    .filter_data (filter_data),
    .threshold   (threshold),
    .enable      (enable),
    .ev_valid    (ev_valid),
    .ev_ready    (ev_ready),
    .ev_amp      (ev_amp),
    .ev_time     (ev_time),
    .ev_pileup   (ev_pileup),
    .busy        (busy),
    .lost_count  (lost_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference timestamp: the value the DUT counter holds between edges.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ts_m <= 0;
    else        ts_m <= ts_m + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard monitor: the offered event must match the queue head on every
  // cycle it is valid; it is retired on the cycle ready is also high.
  always @(negedge clk) begin
    if (rst_n && ev_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_event", {63'd0, ev_valid}, 64'd0);
      end else begin
        check("ev_amp",    64'(ev_amp),    64'(sb[0].amp));
        check("ev_time",   64'(ev_time),   64'(sb[0].t));
        check("ev_pileup", 64'(ev_pileup), 64'(sb[0].pu));
        if (ev_ready) begin
          void'(sb.pop_front());
          n_ev++;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic drive(input int d, output int unsigned t);
    @(posedge clk);
    #1;
    filter_data = DATA_W'(d);
    t = ts_m;  // the timestamp the DUT registers with this sample
  endtask

  task automatic run_seq(input int pk_idx, input logic pu);
    int unsigned t;
    for (int i = 0; i < seq.size(); i++) begin
      drive(seq[i], t);
      if (i == pk_idx) sb.push_back('{amp: DATA_W'(seq[i]), t: t, pu: pu});
    end
  endtask

  task automatic idle(input int n);
    int unsigned t;
    for (int i = 0; i < n; i++) drive(0, t);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_valid"},  64'(ev_valid),   64'd0);
    check({tag, "_amp"},    64'(ev_amp),     64'd0);
    check({tag, "_time"},   64'(ev_time),    64'd0);
    check({tag, "_pileup"}, 64'(ev_pileup),  64'd0);
    check({tag, "_busy"},   64'(busy),       64'd0);
    check({tag, "_lost"},   64'(lost_count), 64'd0);
  endtask

  initial begin
    int unsigned t;
    rst_n       = 1'b0;
    filter_data = '0;
    threshold   = DATA_W'(100);
    enable      = 1'b0;
    ev_ready    = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Single pulse: peak 420 at index 4.
    enable   = 1'b1;
    ev_ready = 1'b1;
    idle(4);
    seq = '{0, 50, 150, 300, 420, 410, 200, 0};
    run_seq(4, 1'b0);
    idle(30);
    check("pulse_events", 64'(n_ev), 64'd1);

    // Monotonic ramp: timeout on the 32nd search sample (index 32 = 520).
    seq.delete();
    for (int i = 0; i < 40; i++) seq.push_back(200 + 10 * i);
    run_seq(32, 1'b1);
    idle(30);
    check("ramp_events", 64'(n_ev), 64'd2);
    check("ramp_lost",   64'(lost_count), 64'd0);

    // Readout stalled for 50 cycles while a second pulse crosses.
    ev_ready = 1'b0;
    seq = '{0, 150, 300, 250, 0};
    run_seq(2, 1'b0);
    seq = '{0, 0, 200, 400, 100, 0};
    run_seq(-1, 1'b0);
    idle(39);
    @(negedge clk);
    check("stall_valid", 64'(ev_valid),   64'd1);
    check("stall_lost",  64'(lost_count), 64'd1);
    check("stall_busy",  64'(busy),       64'd1);
    check("stall_events", 64'(n_ev),      64'd2);
    ev_ready = 1'b1;
    idle(30);
    check("stall_one_event", 64'(n_ev), 64'd3);
    check("stall_lost_hold", 64'(lost_count), 64'd1);

    // Plateau: the first 500 sets the timestamp, the tie does not move it.
    seq = '{0, 200, 500, 500, 499, 0};
    run_seq(2, 1'b0);
    idle(30);
    check("plateau_events", 64'(n_ev), 64'd4);

    // Enable dropped during SEARCH discards the pulse.
    drive(0, t);
    drive(200, t);
    drive(300, t);
    enable = 1'b0;
    drive(400, t);
    drive(450, t);
    drive(500, t);
    @(negedge clk);
    check("disable_busy",   64'(busy),     64'd0);
    check("disable_valid",  64'(ev_valid), 64'd0);
    // Re-enable while already above threshold: no trigger.
    enable = 1'b1;
    for (int i = 0; i < 10; i++) drive(500, t);
    @(negedge clk);
    check("reenable_busy",  64'(busy),     64'd0);
    check("reenable_events", 64'(n_ev),    64'd4);
    seq = '{0, 0, 300, 600, 200, 0};
    run_seq(3, 1'b0);
    idle(30);
    check("rearm_events", 64'(n_ev), 64'd5);

    // Reset while an event is pending.
    ev_ready = 1'b0;
    seq = '{0, 150, 300, 250};
    run_seq(2, 1'b0);
    drive(0, t);
    @(negedge clk);
    check("pre_reset_valid", 64'(ev_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check_outputs_zero("mid_reset");
    sb.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    ev_ready = 1'b1;
    // Timestamps after this point are small: ts restarted from 0.
    seq = '{0, 0, 0, 150, 400, 300, 0};
    run_seq(4, 1'b0);
    idle(10);
    check("post_reset_events", 64'(n_ev), 64'd6);
    check("scoreboard_empty",  64'(sb.size()), 64'd0);
    check("post_reset_lost",   64'(lost_count), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cusp_peak_sequencer.md
# cusp_peak_sequencer

Acquisition sequencer behind the cusp-like shaping filter.
- Watches the filter output stream and arms on a threshold crossing.
- Tracks the pulse to its peak, then hands one event (amplitude, timestamp, pile-up flag) to the readout over a valid/ready handshake.
- Enforces a dead time and re-arm condition, and counts crossings lost while busy.

## Interface
Parameters:
- SHAPE_LEN, 32: maximum cycles from crossing to peak before timeout (≥2).
- DEAD_TIME, 16: cycles blocked after an event is accepted (≥1).
- TS_W, 32: timestamp width.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low; clears all state.
- filter_data  in  SIZE_FILTER_DATA+1  signed filter output, new sample every clk.
- threshold  in  SIZE_FILTER_DATA+1  signed trigger level, sampled every cycle.
- enable  in  1  acquisition enable.
- ev_valid  out  1  event available.
- ev_ready  in  1  readout accepts event.
- ev_amp  out  SIZE_FILTER_DATA+1  signed peak amplitude.
- ev_time  out  TS_W  timestamp of the peak sample.
- ev_pileup  out  1  peak not found within SHAPE_LEN.
- busy  out  1  high in every state except IDLE and ARMED.
- lost_count  out  16  saturating count of crossings missed while busy.

## Operation
- ts: free-running TS_W counter, +1 every clk, wraps to 0, independent of enable.
- above = (filter_data > threshold), signed, strict. above_q is its registered copy. A crossing is above && !above_q.
- States: IDLE, ARMED, SEARCH, OUTPUT, DEAD.
- IDLE: enable=1 -> ARMED.
- ARMED: on a crossing:
  - load amp=filter_data, t_pk=ts, cnt=0.
  - go to SEARCH.
  - A sample already above threshold when arming does not trigger; a fresh crossing is required.
- SEARCH: each cycle cnt+1.
  - filter_data > amp: amp=filter_data, t_pk=ts. Ties keep the earlier sample.
  - filter_data < amp: peak found. Latch ev_amp=amp, ev_time=t_pk, ev_pileup=0; go to OUTPUT.
  - cnt == SHAPE_LEN-1 with no fall: latch ev_amp=amp, ev_time=t_pk, ev_pileup=1; go to OUTPUT.
  - If the fall and the timeout occur in the same cycle, the fall wins (pileup=0).
- OUTPUT: ev_valid=1.
  - ev_amp/ev_time/ev_pileup are held stable until ev_valid && ev_ready at a rising edge.
  - After the transfer: go to DEAD and load the dead counter.
- DEAD: count DEAD_TIME cycles, then stay until above==0, then go to ARMED.
- Lost events: lost_count increments on every crossing in OUTPUT or DEAD. It saturates at 16'hFFFF and is cleared only by reset.
- enable=0:
  - ARMED or SEARCH: go to IDLE next edge; any in-progress search is discarded.
  - OUTPUT: the event is still delivered, then go to IDLE (no DEAD).
  - DEAD: go to IDLE immediately.
- Width rule: amplitude comparisons are signed, at full SIZE_FILTER_DATA+1 width; no truncation.

## Timing
- Reset values: ev_valid=0, ev_amp=0, ev_time=0, ev_pileup=0, busy=0, lost_count=0, state=IDLE, ts=0, above_q=0.
- All outputs are registered; no combinational path from inputs to outputs.
- Crossing sampled at edge E -> state=SEARCH after E.
- Fall sample seen at edge F -> ev_valid=1 after F. Latency from the peak sample: 1 cycle plus the time to observe the fall.
- ev_time equals the ts value at the edge where the peak sample was registered.
- Handshake:
  - ev_ready may be high before ev_valid.
  - Transfer happens at the first edge with both high; ev_valid drops after that edge.
  - No combinational dependence of ev_valid on ev_ready.
- Minimum spacing between accepted events: DEAD_TIME+3 cycles.
- Reset asserted mid-event: everything clears asynchronously and a pending event is dropped.

## Structure
- Shared package cusp_seq_pkg holds:
  - the state enum typedef;
  - LOST_W=16;
  - parameter defaults.
- The package imports SIZE_FILTER_DATA from package_settings.
- One natural sub-module, thr_cross_det: the signed comparator, above_q register and crossing pulse. The rest (FSM, ts, latches, lost counter) stays in this block.

## Test plan
- Single pulse, threshold=100: samples 0,50,150,300,420,410,200,0 -> one event, ev_amp=420, ev_time = ts at the 420 sample, ev_pileup=0.
- Monotonic ramp of +10/cycle from 200 for 40 cycles, SHAPE_LEN=32 -> event with ev_pileup=1 and ev_amp = value of the 32nd SEARCH sample.
- ev_ready held low for 50 cycles while a second pulse crosses -> ev_valid and data held stable, lost_count=1, only one event delivered.
- Plateau 500,500,499 -> ev_time of the first 500 (tie keeps earlier).
- enable dropped during SEARCH -> no event, state=IDLE; re-enable with data already above threshold -> no trigger until the signal falls below and crosses again.
- Reset pulsed while ev_valid=1 -> all outputs 0 immediately; ts restarts from 0.
